mandel_collector: RTL and testbench

Collects per-engine iteration results from the NUM_ENGINES parallel fractal engines fed by the pixel distributor. Once every engine in a batch has finished, it captures all results into a batch buffer and pulses `fin_flag` back to the distributor and engines so they start the next batch. It then serialises the buffered results as a raster-ordered pixel stream with valid/ready handshake, start-of-frame and end-of-line markers, and pixel coordinates for the downstream colour-map / framebuffer writer.

---
 rtl/mandel_collector.sv | 112 +++++++++++
 tb/tb_mandel_collector.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mandel_collector.sv
// mandel_collector
//   Gathers one batch of NUM_ENGINES iteration counts from the parallel fractal
//   engines. Once every engine reports done, it latches the batch and pulses
//   fin_flag for one cycle. It then streams the batch out as raster-ordered
//   pixels on a valid/ready interface.
//
// Ports
//   clk, reset   clock; synchronous active-high reset
//   eng_done     per-engine result-valid level (all ones triggers capture)
//   eng_iter     per-engine iteration counts (unpacked array)
//   fin_flag     one-cycle pulse, batch captured, engines may start next batch
//   out_data     iteration count of the current pixel (0 when not valid)
//   out_x/out_y  raster coordinates of the current pixel
//   out_sof      beat carries pixel (0,0)
//   out_eol      beat carries the last column of a line
//   out_valid    beat valid
//   out_ready    downstream accepts the beat
//   frame_done   one-cycle pulse after the last pixel of a frame is accepted
module mandel_collector #(
  parameter int unsigned PIXEL_DATA_WIDTH = 10,
  parameter int unsigned SCREEN_WIDTH     = 640,
  parameter int unsigned SCREEN_HEIGHT    = 480,
  parameter int unsigned NUM_ENGINES      = 12,
  parameter int unsigned ITER_WIDTH       = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_ENGINES-1:0]      eng_done,
  input  logic [ITER_WIDTH-1:0]       eng_iter [NUM_ENGINES],
  output logic                        fin_flag,
  output logic [ITER_WIDTH-1:0]       out_data,
  output logic [PIXEL_DATA_WIDTH-1:0] out_x,
  output logic [PIXEL_DATA_WIDTH-1:0] out_y,
  output logic                        out_sof,
  output logic                        out_eol,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        frame_done
);

  localparam int unsigned IDX_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam logic [IDX_W-1:0]            IDX_LAST = IDX_W'(NUM_ENGINES - 1);
  localparam logic [PIXEL_DATA_WIDTH-1:0] X_LAST   = PIXEL_DATA_WIDTH'(SCREEN_WIDTH - 1);
  localparam logic [PIXEL_DATA_WIDTH-1:0] Y_LAST   = PIXEL_DATA_WIDTH'(SCREEN_HEIGHT - 1);

  typedef enum logic {WAIT, DRAIN} state_t;

  state_t                      state;
  logic [IDX_W-1:0]            index;
  logic [ITER_WIDTH-1:0]       batch_buf [NUM_ENGINES];
  logic [PIXEL_DATA_WIDTH-1:0] x;
  logic [PIXEL_DATA_WIDTH-1:0] y;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= WAIT;
      index      <= '0;
      x          <= '0;
      y          <= '0;
      fin_flag   <= 1'b0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
        batch_buf[i] <= '0;
      end
    end else begin
      fin_flag   <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        WAIT: begin
          if (&eng_done) begin
            for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
              batch_buf[i] <= eng_iter[i];
            end
            index     <= '0;
            state     <= DRAIN;
            out_valid <= 1'b1;
            fin_flag  <= 1'b1;
          end
        end
        DRAIN: begin
          // out_valid is high throughout DRAIN, so out_ready alone marks acceptance
          if (out_ready) begin
            index <= index + 1'b1;
            if (x == X_LAST) begin
              x <= '0;
              y <= (y == Y_LAST) ? '0 : y + 1'b1;
            end else begin
              x <= x + 1'b1;
            end
            frame_done <= (x == X_LAST) && (y == Y_LAST);
            if (index == IDX_LAST) begin
              index     <= '0;
              state     <= WAIT;
              out_valid <= 1'b0;
            end
          end
        end
        default: state <= WAIT;
      endcase
    end
  end

  always_comb begin
    out_data = out_valid ? batch_buf[index] : '0;
    out_x    = x;
    out_y    = y;
    out_sof  = out_valid && (x == '0) && (y == '0);
    out_eol  = out_valid && (x == X_LAST);
  end

endmodule

// File: tb/tb_mandel_collector.sv
// Testbench for mandel_collector: a reduced screen keeps a full frame short.
// The reference model treats the output as a queue of captured values plus a
// linear pixel number that is mapped to (x, y) with division and modulo.
module tb_mandel_collector;

  localparam int W  = 40;
  localparam int H  = 9;
  localparam int N  = 12;
  localparam int IW = 8;
  localparam int PW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  eng_done;
  logic [IW-1:0] eng_iter [N];
  logic          fin_flag;
  logic [IW-1:0] out_data;
  logic [PW-1:0] out_x;
  logic [PW-1:0] out_y;
  logic          out_sof;
  logic          out_eol;
  logic          out_valid;
  logic          out_ready;
  logic          frame_done;

  mandel_collector #(
    .PIXEL_DATA_WIDTH(PW),
    .SCREEN_WIDTH    (W),
    .SCREEN_HEIGHT   (H),
    .NUM_ENGINES     (N),
    .ITER_WIDTH      (IW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .eng_done  (eng_done),
    .eng_iter  (eng_iter),
    .fin_flag  (fin_flag),
    .out_data  (out_data),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int       pix = 0;          // linear pixel number within the frame
  bit       draining = 1'b0;  // a captured batch still has beats to deliver
  int       expq [$];         // captured values not yet accepted
  int       fin_cnt = 0;
  int       fd_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Predict the effect of the next edge from current inputs, advance one clock,
  // then compare every output against the prediction.
  task automatic cycle();
    bit exp_fin = 1'b0;
    bit exp_fd  = 1'b0;
    bit rst_now = reset;
    if (reset) begin
      draining = 1'b0;
      expq.delete();
      pix = 0;
    end else if (!draining) begin
      if (eng_done == {N{1'b1}}) begin
        for (int i = 0; i < N; i++) expq.push_back(int'(eng_iter[i]));
        draining = 1'b1;
        exp_fin  = 1'b1;
      end
    end else if (out_ready) begin
      void'(expq.pop_front());
      if (pix == W*H-1) exp_fd = 1'b1;
      pix = (pix + 1) % (W*H);
      if (expq.size() == 0) draining = 1'b0;
    end
    @(posedge clk);
    #1;
    if (fin_flag === 1'b1) fin_cnt++;
    if (frame_done === 1'b1) fd_cnt++;
    chk("fin_flag",   32'(fin_flag),   32'(exp_fin));
    chk("frame_done", 32'(frame_done), 32'(exp_fd));
    chk("out_valid",  32'(out_valid),  32'(draining));
    chk("out_x",      32'(out_x),      32'(pix % W));
    chk("out_y",      32'(out_y),      32'(pix / W));
    chk("out_sof",    32'(out_sof),    32'(draining && pix == 0));
    chk("out_eol",    32'(out_eol),    32'(draining && (pix % W) == W-1));
    if (draining) chk("out_data", 32'(out_data), 32'(expq[0]));
    if (rst_now)  chk("out_data_rst", 32'(out_data), 32'd0);
  endtask

  initial begin
    int fd_before;
    int fin_before;
    reset     = 1'b1;
    eng_done  = '1;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) eng_iter[i] = IW'(i + 1);

    // reset held with all engines done: reset wins, outputs stay at 0
    repeat (2) cycle();

    // single batch: first capture on the first edge after release
    reset = 1'b0;
    cycle();
    chk("fin_after_reset", 32'(fin_cnt), 32'd1);
    eng_done = '0;
    repeat (14) cycle();
    chk("single_batch_fin_count", 32'(fin_cnt), 32'd1);
    chk("single_batch_pos", 32'(pix), 32'd12);

    // partial done: engine 11 late for 20 cycles
    for (int i = 0; i < N; i++) eng_iter[i] = IW'($urandom);
    eng_done = 12'h7FF;
    repeat (20) cycle();
    chk("partial_no_fin", 32'(fin_cnt), 32'd1);
    eng_done = 12'hFFF;
    cycle();
    eng_done = '0;

    // backpressure: ready pattern 1,0,0 repeating
    for (int k = 0; k < 40; k++) begin
      out_ready = (k % 3 == 0);
      cycle();
    end
    chk("backpressure_pos", 32'(pix), 32'd24);
    chk("backpressure_fin_count", 32'(fin_cnt), 32'd2);

    // continuous always-done batches through a frame wrap (batches straddle lines)
    out_ready  = 1'b1;
    eng_done   = '1;
    fin_before = fin_cnt;
    for (int k = 0; k < 13*32; k++) begin
      for (int i = 0; i < N; i++) eng_iter[i] = IW'($urandom);
      cycle();
    end
    chk("continuous_fin_rate", 32'(fin_cnt - fin_before), 32'd32);
    chk("frame_done_once", 32'(fd_cnt), 32'd1);

    // random backpressure across another frame boundary
    fd_before = fd_cnt;
    for (int k = 0; k < 700; k++) begin
      for (int i = 0; i < N; i++) eng_iter[i] = IW'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    chk("random_frame_done", 32'(fd_cnt - fd_before), 32'd1);

    // let the current batch finish before the mid-drain reset test
    eng_done  = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 30 && draining; k++) cycle();
    chk("drain_timeout", 32'(draining), 32'd0);

    // reset after beat 5 is accepted
    for (int i = 0; i < N; i++) eng_iter[i] = IW'($urandom);
    eng_done = '1;
    cycle();
    eng_done = '0;
    repeat (6) cycle();
    fin_before = fin_cnt;
    reset = 1'b1;
    cycle();
    chk("mid_reset_valid", 32'(out_valid), 32'd0);
    chk("mid_reset_x", 32'(out_x), 32'd0);
    reset = 1'b0;
    repeat (20) cycle();
    chk("no_stale_fin", 32'(fin_cnt - fin_before), 32'd0);

    // a fresh batch after the reset starts at (0,0)
    for (int i = 0; i < N; i++) eng_iter[i] = IW'($urandom);
    eng_done = '1;
    cycle();
    eng_done = '0;
    repeat (14) cycle();
    chk("post_reset_pos", 32'(pix), 32'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
